// File: rtl/usb_hub_pkg.sv
// Shared definitions for the USB hub datapath.
//   - Line-state encodings as {D+, D-}.
//   - rpt_state_e: repeater FSM states (also exported on the debug port).
//   - BABBLE_LIMIT_DEFAULT: default maximum upstream packet length, shared
//     with the hub controller.
package usb_hub_pkg;

  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  localparam int BABBLE_LIMIT_DEFAULT = 12000;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DOWN      = 3'd1,
    ST_UP        = 3'd2,
    ST_FORCE_EOP = 3'd3,
    ST_EOP_HOLD  = 3'd4
  } rpt_state_e;

endpackage

// File: rtl/usb_eop_detect.sv
// End-of-packet detector: flags a J sample that follows one or more SE0
// samples since the last clear.
//   i_clk    clock
//   i_reset  synchronous active-high reset
//   i_clear  clears the SE0-seen flag (held while the repeater is idle)
//   i_line   {D+, D-} sample of the line being watched
//   o_eop    combinational EOP indication for the current sample
module usb_eop_detect
  import usb_hub_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_clear,
  input  logic [1:0] i_line,
  output logic       o_eop
);

  logic r_se0_seen;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_se0_seen <= 1'b0;
    end else if (i_line == LINE_SE0) begin
      r_se0_seen <= 1'b1;
    end
  end

  assign o_eop = r_se0_seen && (i_line == LINE_J);

endmodule

// File: rtl/usb_hub_repeater.sv
// Packet repeater between the upstream (host) transceiver and
// NUM_USB_DEVICES downstream transceivers, one cycle of registered latency.
//   i_hi_clock, i_reset               clock, synchronous active-high reset
//   i_host_rx_plus/minus              host line state in
//   o_host_tx_plus/minus, o_host_tx_oe repeated state toward host, drive enable
//   i_dev_rx_plus/minus  [N]          device line states in
//   o_dev_tx_plus/minus  [N]          repeated state toward devices
//   o_dev_tx_oe          [N]          per-port drive enable
//   i_port_enable        [N]          per-port enable from hub controller
//   o_babble_detect      [N]          sticky babble flag, cleared by disable
//   o_active_port                     upstream owner (valid in UP/FORCE_EOP)
//   o_rpt_state                       FSM state for debug
//
// state        | meaning
// IDLE         | all tx = J, all oe low, waiting for SOP K on either side
// DOWN         | host line repeated to all eligible ports
// UP           | active port repeated to host, babble counter running
// FORCE_EOP    | SE0 driven upstream for two cycles after babble/disable
// EOP_HOLD     | J driven for one cycle with the previous oe still high
module usb_hub_repeater
  import usb_hub_pkg::*;
#(
  parameter  int NUM_USB_DEVICES = 4,
  parameter  int BABBLE_LIMIT    = BABBLE_LIMIT_DEFAULT,
  localparam int PORT_W          = (NUM_USB_DEVICES > 1) ? $clog2(NUM_USB_DEVICES) : 1
) (
  input  logic                       i_hi_clock,
  input  logic                       i_reset,
  input  logic                       i_host_rx_plus,
  input  logic                       i_host_rx_minus,
  output logic                       o_host_tx_plus,
  output logic                       o_host_tx_minus,
  output logic                       o_host_tx_oe,
  input  logic [NUM_USB_DEVICES-1:0] i_dev_rx_plus,
  input  logic [NUM_USB_DEVICES-1:0] i_dev_rx_minus,
  output logic [NUM_USB_DEVICES-1:0] o_dev_tx_plus,
  output logic [NUM_USB_DEVICES-1:0] o_dev_tx_minus,
  output logic [NUM_USB_DEVICES-1:0] o_dev_tx_oe,
  input  logic [NUM_USB_DEVICES-1:0] i_port_enable,
  output logic [NUM_USB_DEVICES-1:0] o_babble_detect,
  output logic [PORT_W-1:0]          o_active_port,
  output logic [2:0]                 o_rpt_state
);

  localparam int              CNT_W   = $clog2(BABBLE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BABBLE_LIMIT);
  localparam int              N       = NUM_USB_DEVICES;

  rpt_state_e       r_state, w_state_nxt;
  logic [1:0]       r_host_tx, w_host_tx_nxt;
  logic             r_host_tx_oe, w_host_tx_oe_nxt;
  logic [N-1:0]     r_dev_tx_plus, w_dev_tx_plus_nxt;
  logic [N-1:0]     r_dev_tx_minus, w_dev_tx_minus_nxt;
  logic [N-1:0]     r_dev_tx_oe, w_dev_tx_oe_nxt;
  logic [N-1:0]     r_babble, w_babble_nxt;
  logic [PORT_W-1:0] r_active_port, w_active_port_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_force, w_force_nxt;

  logic [1:0]       w_host_line, w_up_line, w_eop_line;
  logic [N-1:0]     w_eligible, w_dev_k;
  logic             w_any_dev_k, w_babble_hit, w_eop, w_eop_clear;
  logic [PORT_W-1:0] w_low_idx;

  assign w_host_line = {i_host_rx_plus, i_host_rx_minus};
  assign w_up_line   = {i_dev_rx_plus[r_active_port], i_dev_rx_minus[r_active_port]};
  assign w_eligible  = i_port_enable & ~r_babble;
  assign w_dev_k     = w_eligible & ~i_dev_rx_plus & i_dev_rx_minus;
  assign w_eop_line  = (r_state == ST_UP) ? w_up_line : w_host_line;
  assign w_eop_clear = (r_state == ST_IDLE);

  usb_eop_detect u_eop_detect (
    .i_clk   (i_hi_clock),
    .i_reset (i_reset),
    .i_clear (w_eop_clear),
    .i_line  (w_eop_line),
    .o_eop   (w_eop)
  );

  // Scan from the top so the lowest requesting index is the one left standing.
  always_comb begin
    w_any_dev_k = 1'b0;
    w_low_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_dev_k[i]) begin
        w_any_dev_k = 1'b1;
        w_low_idx   = PORT_W'(i);
      end
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_host_tx_nxt      = LINE_J;
    w_host_tx_oe_nxt   = 1'b0;
    w_dev_tx_plus_nxt  = '1;
    w_dev_tx_minus_nxt = '0;
    w_dev_tx_oe_nxt    = '0;
    w_active_port_nxt  = r_active_port;
    w_cnt_nxt          = r_cnt;
    w_force_nxt        = r_force;
    w_babble_hit       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_host_line == LINE_K) begin
          w_state_nxt        = ST_DOWN;
          w_dev_tx_plus_nxt  = {N{w_host_line[1]}};
          w_dev_tx_minus_nxt = {N{w_host_line[0]}};
          w_dev_tx_oe_nxt    = w_eligible;
        end else if (w_any_dev_k) begin
          w_state_nxt       = ST_UP;
          w_active_port_nxt = w_low_idx;
          w_cnt_nxt         = '0;
          w_host_tx_nxt     = LINE_K;
          w_host_tx_oe_nxt  = 1'b1;
        end
      end
      ST_DOWN: begin
        w_dev_tx_plus_nxt  = {N{w_host_line[1]}};
        w_dev_tx_minus_nxt = {N{w_host_line[0]}};
        w_dev_tx_oe_nxt    = w_eligible;
        if (w_eop) w_state_nxt = ST_EOP_HOLD;
      end
      ST_UP: begin
        w_host_tx_nxt    = w_up_line;
        w_host_tx_oe_nxt = 1'b1;
        w_cnt_nxt        = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
        // Terminal count is checked on the registered value, so the packet
        // gets exactly BABBLE_LIMIT counted cycles before being cut off.
        if (!i_port_enable[r_active_port] || (r_cnt == CNT_MAX)) begin
          w_state_nxt   = ST_FORCE_EOP;
          w_host_tx_nxt = LINE_SE0;
          w_force_nxt   = 1'b0;
          w_babble_hit  = (r_cnt == CNT_MAX);
        end else if (w_eop) begin
          w_state_nxt = ST_EOP_HOLD;
        end
      end
      ST_FORCE_EOP: begin
        w_host_tx_oe_nxt = 1'b1;
        if (!r_force) begin
          w_host_tx_nxt = LINE_SE0;
          w_force_nxt   = 1'b1;
        end else begin
          w_state_nxt = ST_EOP_HOLD;
        end
      end
      ST_EOP_HOLD: w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase

    // Disable always wins, so a disabled port can never hold a stale flag.
    for (int i = 0; i < N; i++) begin
      w_babble_nxt[i] = i_port_enable[i] &
                        (r_babble[i] | (w_babble_hit && (r_active_port == PORT_W'(i))));
    end
  end

  always_ff @(posedge i_hi_clock) begin
    if (i_reset) begin
      r_state        <= ST_IDLE;
      r_host_tx      <= LINE_J;
      r_host_tx_oe   <= 1'b0;
      r_dev_tx_plus  <= '1;
      r_dev_tx_minus <= '0;
      r_dev_tx_oe    <= '0;
      r_babble       <= '0;
      r_active_port  <= '0;
      r_cnt          <= '0;
      r_force        <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_host_tx      <= w_host_tx_nxt;
      r_host_tx_oe   <= w_host_tx_oe_nxt;
      r_dev_tx_plus  <= w_dev_tx_plus_nxt;
      r_dev_tx_minus <= w_dev_tx_minus_nxt;
      r_dev_tx_oe    <= w_dev_tx_oe_nxt;
      r_babble       <= w_babble_nxt;
      r_active_port  <= w_active_port_nxt;
      r_cnt          <= w_cnt_nxt;
      r_force        <= w_force_nxt;
    end
  end

  assign o_host_tx_plus  = r_host_tx[1];
  assign o_host_tx_minus = r_host_tx[0];
  assign o_host_tx_oe    = r_host_tx_oe;
  assign o_dev_tx_plus   = r_dev_tx_plus;
  assign o_dev_tx_minus  = r_dev_tx_minus;
  assign o_dev_tx_oe     = r_dev_tx_oe;
  assign o_babble_detect = r_babble;
  assign o_active_port   = r_active_port;
  assign o_rpt_state     = r_state;

endmodule

// File: tb/tb_usb_hub_repeater.sv
// Scoreboard bench for usb_hub_repeater (4 ports, babble limit 16).
// Each step drives one cycle of stimulus and queues the outputs expected
// after the next rising edge; the monitor pops and compares them.
module tb_usb_hub_repeater;
  import usb_hub_pkg::*;

  localparam int N   = 4;
  localparam int LIM = 16;
  localparam logic [1:0] LJ = 2'b10;
  localparam logic [1:0] LK = 2'b01;
  localparam logic [1:0] LS = 2'b00;

  typedef struct packed {
    int             id;
    logic [1:0]     host_tx;
    logic           host_oe;
    logic [3:0][1:0] dev_tx;
    logic [3:0]     dev_oe;
    logic [3:0]     bab;
    logic [2:0]     st;
    logic           ap_chk;
    logic [1:0]     ap;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      host;
  logic [3:0][1:0] dev;
  logic [3:0]      en;
  logic [3:0]      dp, dm;

  logic            o_host_tx_plus, o_host_tx_minus, o_host_tx_oe;
  logic [3:0]      o_dev_tx_plus, o_dev_tx_minus, o_dev_tx_oe, o_babble_detect;
  logic [1:0]      o_active_port;
  logic [2:0]      o_rpt_state;
  logic [3:0][1:0] got_dev;

  exp_t q[$];
  exp_t m_e;
  int   n_checks = 0;
  int   n_errors = 0;
  int   step_no  = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      dp[i]      = dev[i][1];
      dm[i]      = dev[i][0];
      got_dev[i] = {o_dev_tx_plus[i], o_dev_tx_minus[i]};
    end
  end

  usb_hub_repeater #(
    .NUM_USB_DEVICES (N),
    .BABBLE_LIMIT    (LIM)
  ) dut (
    .i_hi_clock      (clk),
    .i_reset         (rst),
    .i_host_rx_plus  (host[1]),
    .i_host_rx_minus (host[0]),
    .o_host_tx_plus  (o_host_tx_plus),
    .o_host_tx_minus (o_host_tx_minus),
    .o_host_tx_oe    (o_host_tx_oe),
    .i_dev_rx_plus   (dp),
    .i_dev_rx_minus  (dm),
    .o_dev_tx_plus   (o_dev_tx_plus),
    .o_dev_tx_minus  (o_dev_tx_minus),
    .o_dev_tx_oe     (o_dev_tx_oe),
    .i_port_enable   (en),
    .o_babble_detect (o_babble_detect),
    .o_active_port   (o_active_port),
    .o_rpt_state     (o_rpt_state)
  );

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0][1:0] dv(input logic [1:0] d3, input logic [1:0] d2,
                                         input logic [1:0] d1, input logic [1:0] d0);
    return {d3, d2, d1, d0};
  endfunction

  function automatic exp_t e_idle(input logic [3:0] bab);
    exp_t e;
    e         = '0;
    e.host_tx = LJ;
    e.dev_tx  = {LJ, LJ, LJ, LJ};
    e.bab     = bab;
    e.st      = ST_IDLE;
    return e;
  endfunction

  function automatic exp_t e_down(input logic [1:0] l, input logic [3:0] oe, input logic [2:0] st);
    exp_t e;
    e         = '0;
    e.host_tx = LJ;
    e.dev_tx  = {l, l, l, l};
    e.dev_oe  = oe;
    e.st      = st;
    return e;
  endfunction

  function automatic exp_t e_up(input logic [1:0] l, input logic [1:0] ap,
                                input logic [2:0] st, input logic [3:0] bab);
    exp_t e;
    e         = '0;
    e.host_tx = l;
    e.host_oe = 1'b1;
    e.dev_tx  = {LJ, LJ, LJ, LJ};
    e.bab     = bab;
    e.st      = st;
    e.ap      = ap;
    e.ap_chk  = (st == ST_UP) || (st == ST_FORCE_EOP);
    return e;
  endfunction

  task automatic step(input logic rs, input logic [1:0] h, input logic [3:0][1:0] d,
                      input logic [3:0] pe, input exp_t e);
    @(negedge clk);
    rst  = rs;
    host = h;
    dev  = d;
    en   = pe;
    e.id = step_no;
    step_no++;
    q.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      m_e = q.pop_front();
      chk_val($sformatf("s%0d host_tx", m_e.id), {o_host_tx_plus, o_host_tx_minus}, m_e.host_tx);
      chk_val($sformatf("s%0d host_oe", m_e.id), o_host_tx_oe, m_e.host_oe);
      chk_val($sformatf("s%0d dev_tx", m_e.id), got_dev, m_e.dev_tx);
      chk_val($sformatf("s%0d dev_oe", m_e.id), o_dev_tx_oe, m_e.dev_oe);
      chk_val($sformatf("s%0d babble", m_e.id), o_babble_detect, m_e.bab);
      chk_val($sformatf("s%0d state", m_e.id), o_rpt_state, m_e.st);
      if (m_e.ap_chk) chk_val($sformatf("s%0d active_port", m_e.id), o_active_port, m_e.ap);
    end
  end

  initial begin
    exp_t            e;
    logic [3:0][1:0] dj;
    dj   = dv(LJ, LJ, LJ, LJ);
    rst  = 1'b1;
    host = LJ;
    dev  = dj;
    en   = 4'hF;

    // Reset dominates a host SOP.
    e = e_idle(4'h0); e.ap_chk = 1'b1; e.ap = 2'd0;
    step(1'b1, LK, dj, 4'hF, e);
    step(1'b1, LJ, dj, 4'hF, e);
    step(1'b0, LJ, dj, 4'hF, e_idle(4'h0));

    // Downstream packet K,J,K,SE0,SE0,J.
    step(1'b0, LK, dj, 4'hF, e_down(LK, 4'hF, ST_DOWN));
    step(1'b0, LJ, dj, 4'hF, e_down(LJ, 4'hF, ST_DOWN));
    step(1'b0, LK, dj, 4'hF, e_down(LK, 4'hF, ST_DOWN));
    step(1'b0, LS, dj, 4'hF, e_down(LS, 4'hF, ST_DOWN));
    step(1'b0, LS, dj, 4'hF, e_down(LS, 4'hF, ST_DOWN));
    step(1'b0, LJ, dj, 4'hF, e_down(LJ, 4'hF, ST_EOP_HOLD));
    step(1'b0, LJ, dj, 4'hF, e_idle(4'h0));
    step(1'b0, LJ, dj, 4'hF, e_idle(4'h0));

    // Host and device 2 SOP together: host wins, device 2 ignored.
    step(1'b0, LK, dv(LJ, LK, LJ, LJ), 4'hF, e_down(LK, 4'hF, ST_DOWN));
    step(1'b0, LJ, dv(LJ, LK, LJ, LJ), 4'hF, e_down(LJ, 4'hF, ST_DOWN));
    step(1'b0, LS, dv(LJ, LK, LJ, LJ), 4'hF, e_down(LS, 4'hF, ST_DOWN));
    step(1'b0, LJ, dv(LJ, LK, LJ, LJ), 4'hF, e_down(LJ, 4'hF, ST_EOP_HOLD));
    step(1'b0, LJ, dj, 4'hF, e_idle(4'h0));

    // Devices 1 and 3 together: lowest index owns the bus.
    step(1'b0, LJ, dv(LK, LJ, LK, LJ), 4'hF, e_up(LK, 2'd1, ST_UP, 4'h0));
    step(1'b0, LJ, dv(LK, LJ, LS, LJ), 4'hF, e_up(LS, 2'd1, ST_UP, 4'h0));
    step(1'b0, LJ, dv(LK, LJ, LJ, LJ), 4'hF, e_up(LJ, 2'd1, ST_EOP_HOLD, 4'h0));
    step(1'b0, LJ, dj, 4'hF, e_idle(4'h0));

    // Port 3 disabled mid-DOWN.
    step(1'b0, LK, dj, 4'hF, e_down(LK, 4'hF, ST_DOWN));
    step(1'b0, LJ, dj, 4'h7, e_down(LJ, 4'h7, ST_DOWN));
    step(1'b0, LS, dj, 4'h7, e_down(LS, 4'h7, ST_DOWN));
    step(1'b0, LJ, dj, 4'h7, e_down(LJ, 4'h7, ST_EOP_HOLD));
    step(1'b0, LJ, dj, 4'hF, e_idle(4'h0));

    // Active port 2 disabled mid-UP: forced EOP, no babble flag.
    step(1'b0, LJ, dv(LJ, LK, LJ, LJ), 4'hF, e_up(LK, 2'd2, ST_UP, 4'h0));
    step(1'b0, LJ, dj, 4'hB, e_up(LS, 2'd2, ST_FORCE_EOP, 4'h0));
    step(1'b0, LJ, dj, 4'hB, e_up(LS, 2'd2, ST_FORCE_EOP, 4'h0));
    step(1'b0, LJ, dj, 4'hB, e_up(LJ, 2'd2, ST_EOP_HOLD, 4'h0));
    step(1'b0, LJ, dj, 4'hF, e_idle(4'h0));

    // Babble: device 0 holds K for 40 cycles with limit 16.
    for (int k = 0; k < 40; k++) begin
      if (k <= LIM)          e = e_up(LK, 2'd0, ST_UP, 4'h0);
      else if (k <= LIM + 2) e = e_up(LS, 2'd0, ST_FORCE_EOP, 4'h1);
      else if (k == LIM + 3) e = e_up(LJ, 2'd0, ST_EOP_HOLD, 4'h1);
      else                   e = e_idle(4'h1);
      step(1'b0, LJ, dv(LJ, LJ, LJ, LK), 4'hF, e);
    end
    step(1'b0, LJ, dj, 4'hE, e_idle(4'h0));
    step(1'b0, LJ, dv(LJ, LJ, LJ, LK), 4'hF, e_up(LK, 2'd0, ST_UP, 4'h0));
    step(1'b0, LJ, dv(LJ, LJ, LJ, LS), 4'hF, e_up(LS, 2'd0, ST_UP, 4'h0));
    step(1'b0, LJ, dv(LJ, LJ, LJ, LJ), 4'hF, e_up(LJ, 2'd0, ST_EOP_HOLD, 4'h0));
    step(1'b0, LJ, dj, 4'hF, e_idle(4'h0));

    // Reset in the middle of an upstream packet.
    step(1'b0, LJ, dv(LJ, LJ, LK, LJ), 4'hF, e_up(LK, 2'd1, ST_UP, 4'h0));
    step(1'b0, LJ, dv(LJ, LJ, LK, LJ), 4'hF, e_up(LK, 2'd1, ST_UP, 4'h0));
    e = e_idle(4'h0); e.ap_chk = 1'b1; e.ap = 2'd0;
    step(1'b1, LJ, dv(LJ, LJ, LK, LJ), 4'hF, e);
    step(1'b0, LJ, dj, 4'hF, e_idle(4'h0));

    @(negedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
